// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one shift/add micro-rotation per clock, rotation or vectoring mode.
// Optional CORDIC_QUADRANT_EN folds operands into the convergence range on the load edge.
module cordic_iter_engine #(
    parameter int WIDTH = 21,
    parameter int FRAC  = 16,
    parameter int ITERS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic             busy
);

    localparam int IW = 5;
    localparam int SH = 30 - FRAC;
    localparam logic [63:0] HALF = (64'd1 << SH) >> 1;
    localparam logic [IW-1:0] LAST = IW'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [IW-1:0] iter;
    logic          mode_q;
    logic signed [WIDTH-1:0] x_q, y_q, z_q;
    logic signed [WIDTH-1:0] x_nx, y_nx, z_nx;
    logic signed [WIDTH-1:0] xs, ys, at;
    logic signed [WIDTH-1:0] ix, iy, iz;
    logic signed [WIDTH-1:0] xl, yl, zl;
    logic dpos;
    logic load;

    // atan(2^-k) in Q2.30, rescaled to FRAC bits with round-half-up
    function automatic logic [WIDTH-1:0] atan_q(input logic [IW-1:0] k);
        logic [63:0] raw;
        raw = 64'd0;
        case (k)
            5'd0:    raw = 64'd843314857;
            5'd1:    raw = 64'd497837829;
            5'd2:    raw = 64'd263043837;
            5'd3:    raw = 64'd133525159;
            5'd4:    raw = 64'd67021687;
            5'd5:    raw = 64'd33543516;
            5'd6:    raw = 64'd16775851;
            5'd7:    raw = 64'd8388437;
            5'd8:    raw = 64'd4194283;
            5'd9:    raw = 64'd2097149;
            5'd10:   raw = 64'd1048576;
            5'd11:   raw = 64'd524288;
            5'd12:   raw = 64'd262144;
            5'd13:   raw = 64'd131072;
            5'd14:   raw = 64'd65536;
            5'd15:   raw = 64'd32768;
            5'd16:   raw = 64'd16384;
            5'd17:   raw = 64'd8192;
            5'd18:   raw = 64'd4096;
            5'd19:   raw = 64'd2048;
            5'd20:   raw = 64'd1024;
            5'd21:   raw = 64'd512;
            5'd22:   raw = 64'd256;
            5'd23:   raw = 64'd128;
            default: raw = 64'd0;
        endcase
        return WIDTH'((raw + HALF) >> SH);
    endfunction

    assign ix = in_x;
    assign iy = in_y;
    assign iz = in_z;

`ifdef CORDIC_QUADRANT_EN
    localparam logic signed [WIDTH-1:0] PI   = WIDTH'((64'd3373259426 + HALF) >> SH);
    localparam logic signed [WIDTH-1:0] PI_2 = WIDTH'((64'd1686629713 + HALF) >> SH);

    always_comb begin
        xl = ix;
        yl = iy;
        zl = iz;
        if (!in_mode) begin
            if (iz > PI_2) begin
                xl = -ix;
                yl = -iy;
                zl = iz - PI;
            end else if (iz < -PI_2) begin
                xl = -ix;
                yl = -iy;
                zl = iz + PI;
            end
        end else if (ix[WIDTH-1]) begin
            xl = -ix;
            yl = -iy;
            zl = iy[WIDTH-1] ? iz - PI : iz + PI;
        end
    end
`else
    always_comb begin
        xl = ix;
        yl = iy;
        zl = iz;
    end
`endif

    assign load = in_valid && (state == IDLE);

    // Shared micro-rotation stage; d=+1 when dpos
    always_comb begin
        xs   = x_q >>> iter;
        ys   = y_q >>> iter;
        at   = atan_q(iter);
        dpos = mode_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
        x_nx = dpos ? x_q - ys : x_q + ys;
        y_nx = dpos ? y_q + xs : y_q - xs;
        z_nx = dpos ? z_q - at : z_q + at;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid) state_nx = ROT;
            ROT:  if (iter == LAST) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iter   <= '0;
            mode_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
        end else if (load) begin
            iter   <= '0;
            mode_q <= in_mode;
            x_q    <= xl;
            y_q    <= yl;
            z_q    <= zl;
        end else if (state == ROT) begin
            iter <= iter + 1'b1;
            x_q  <= x_nx;
            y_q  <= y_nx;
            z_q  <= z_nx;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_z     = z_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed testbench for cordic_iter_engine (WIDTH=21, FRAC=16, ITERS=16).
module tb_cordic_iter_engine;

    localparam int W = 21;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [W-1:0] in_x, in_y, in_z;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_x, out_y, out_z;
    logic         busy;

    int compared = 0;
    int mismatched = 0;
    int lat;
    int hx, hy, hz;

    always #5 clk = ~clk;

    cordic_iter_engine #(.WIDTH(21), .FRAC(16), .ITERS(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .busy(busy)
    );

    function automatic int sv(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string tag, input int got, input int exp, input int tol);
        compared++;
        assert (((got - exp <= tol) && (exp - got <= tol)) === 1'b1)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic start(input logic m, input int x, input int y, input int z);
        in_mode  = m;
        in_x     = W'(x);
        in_y     = W'(y);
        in_z     = W'(z);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_mode = 1'b0;
        in_x = '0;
        in_y = '0;
        in_z = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_in_ready", int'(in_ready), 1, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_busy", int'(busy), 0, 0);
        chk("rst_out_x", sv(out_x), 0, 0);

        // T1 rotation by zero
        start(1'b0, 39797, 0, 0);
        chk("t1_busy", int'(busy), 1, 0);
        wait_done(lat);
        chk("t1_latency", lat, 16, 0);
        chk("t1_x", sv(out_x), 65536, 8);
        chk("t1_y", sv(out_y), 0, 8);
        chk("t1_z", sv(out_z), 0, 2);
        release_out();

        // T2 rotation by pi/3
        start(1'b0, 39797, 0, 68629);
        wait_done(lat);
        chk("t2_latency", lat, 16, 0);
        chk("t2_x", sv(out_x), 32768, 8);
        chk("t2_y", sv(out_y), 56756, 8);
        release_out();

        // T3 vectoring of (1,1)
        start(1'b1, 65536, 65536, 0);
        wait_done(lat);
        chk("t3_latency", lat, 16, 0);
        chk("t3_z", sv(out_z), 51472, 8);
        chk("t3_x", sv(out_x), 152625, 8);
        chk("t3_y", sv(out_y), 0, 16);
        release_out();

        // T4 backpressure on T2
        start(1'b0, 39797, 0, 68629);
        wait_done(lat);
        chk("t4_latency", lat, 16, 0);
        hx = sv(out_x);
        hy = sv(out_y);
        hz = sv(out_z);
        chk("t4_x", hx, 32768, 8);
        chk("t4_y", hy, 56756, 8);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("t4_hold_valid", int'(out_valid), 1, 0);
            chk("t4_hold_in_ready", int'(in_ready), 0, 0);
            chk("t4_hold_x", sv(out_x), hx, 0);
            chk("t4_hold_y", sv(out_y), hy, 0);
            chk("t4_hold_z", sv(out_z), hz, 0);
        end
        in_valid = 1'b0;
        release_out();
        chk("t4_in_ready", int'(in_ready), 1, 0);
        chk("t4_out_valid", int'(out_valid), 0, 0);
        chk("t4_busy", int'(busy), 0, 0);

        // T5 reset during step 7
        start(1'b0, 39797, 0, 68629);
        repeat (7) @(posedge clk);
        #1;
        chk("t5_busy_mid", int'(busy), 1, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_out_valid", int'(out_valid), 0, 0);
        chk("t5_in_ready", int'(in_ready), 1, 0);
        chk("t5_busy", int'(busy), 0, 0);
        start(1'b0, 39797, 0, 0);
        wait_done(lat);
        chk("t5_latency", lat, 16, 0);
        chk("t5_x", sv(out_x), 65536, 8);
        chk("t5_y", sv(out_y), 0, 8);
        release_out();

        // T6 rotation by pi
        start(1'b0, 39797, 0, 205887);
        wait_done(lat);
        chk("t6_latency", lat, 16, 0);
`ifdef CORDIC_QUADRANT_EN
        chk("t6_x", sv(out_x), -65536, 8);
        chk("t6_y", sv(out_y), 0, 8);
`endif
        release_out();
        chk("t6_idle", int'(in_ready), 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
